// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared types and constants for the stopwatch timekeeping core.
//   sw_state_e      : RUN / PAUSED / ADJUST
//   DIGIT_W         : width of one BCD digit
//   SEC_MAX         : largest seconds value (fixed)
//   MAX_MIN_DEFAULT : default largest minutes value
//   bcd2_inc()      : advance a two-digit BCD field with wrap to 00
// Optional feature macro used by the design: STOPWATCH_ADJ_EN
// -----------------------------------------------------------------------------
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_ADJUST = 2'd2
  } sw_state_e;

  localparam int DIGIT_W         = 4;
  localparam int SEC_MAX         = 59;
  localparam int MAX_MIN_DEFAULT = 59;

  // Each digit is its own BCD counter; the ones digit carries into the tens
  // digit using only the current digit values, and the pair wraps to 00
  // once it sits at its maximum.
  function automatic logic [2*DIGIT_W-1:0] bcd2_inc(
    input logic [DIGIT_W-1:0] tens,
    input logic [DIGIT_W-1:0] ones,
    input logic [DIGIT_W-1:0] max_tens,
    input logic [DIGIT_W-1:0] max_ones
  );
    logic [2*DIGIT_W-1:0] res;
    if ((tens == max_tens) && (ones == max_ones)) begin
      res = {4'd0, 4'd0};
    end else if (ones == 4'd9) begin
      res = {tens + 4'd1, 4'd0};
    end else begin
      res = {tens, ones + 4'd1};
    end
    return res;
  endfunction

endpackage

// File: rtl/stopwatch_counter_tick_sync.sv
// -----------------------------------------------------------------------------
// tick_sync
// Two-flop synchronizer followed by a rising-edge detector. Turns a slow
// divider square wave into a one-cycle tick in the system clock domain.
// Ports:
//   clk   : system clock
//   rst   : synchronous active-high reset (clears all three flops)
//   din   : asynchronous square wave, sampled as data
//   level : synchronized level of din
//   pulse : one clk cycle high, the cycle after the second sync flop rises
// -----------------------------------------------------------------------------
module tick_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic pulse
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchronizer chain plus one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign level = sync_r;
  assign pulse = sync_r & ~prev_r;

endmodule

// File: rtl/stopwatch_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_counter
// Timekeeping core: counts MM:SS in four BCD digits from the 1 Hz divider
// output, with run/pause, wrap-around and an optional adjust mode.
// Optional feature macro: STOPWATCH_ADJ_EN (ADJUST state, 2 Hz tick, blink).
// Ports:
//   sclk      : system clock
//   rst       : synchronous active-high reset
//   clk_1hz   : 1 Hz square wave (data, not a clock)
//   clk_2hz   : 2 Hz square wave (data, not a clock)
//   pause_tgl : one-cycle pulse toggling RUN/PAUSED
//   adj       : level, selects ADJUST
//   sel       : adjust field, 0 = minutes, 1 = seconds
//   min_tens/min_ones/sec_tens/sec_ones : registered BCD digits
//   wrap      : one-cycle pulse after rolling MAX_MIN:59 -> 00:00
//   blink_min/blink_sec : registered blanking requests for the display
// -----------------------------------------------------------------------------
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN = MAX_MIN_DEFAULT
) (
  input  logic         sclk,
  input  logic         rst,
  input  logic         clk_1hz,
  input  logic         clk_2hz,
  input  logic         pause_tgl,
  input  logic         adj,
  input  logic         sel,
  output logic [3:0]   min_tens,
  output logic [3:0]   min_ones,
  output logic [3:0]   sec_tens,
  output logic [3:0]   sec_ones,
  output logic         wrap,
  output logic         blink_min,
  output logic         blink_sec
);

  localparam logic [3:0] SEC_TENS_MAX = 4'(SEC_MAX / 10);
  localparam logic [3:0] SEC_ONES_MAX = 4'(SEC_MAX % 10);
  localparam logic [3:0] MIN_TENS_MAX = 4'(MAX_MIN / 10);
  localparam logic [3:0] MIN_ONES_MAX = 4'(MAX_MIN % 10);

  sw_state_e  state_r;
  sw_state_e  state_next_s;
  logic [3:0] min_tens_r, min_ones_r, sec_tens_r, sec_ones_r;
  logic       wrap_r, blink_min_r, blink_sec_r;

  logic       tick1_s, lvl1_unused_s;
  logic       tick2_s, lvl2_s, adj_s, sel_s;
  logic       inc_sec_s, inc_min_s, wrap_next_s;
  logic       blink_min_next_s, blink_sec_next_s;
  logic       sec_at_max_s, min_at_max_s;
  logic [7:0] sec_inc_s, min_inc_s;

  tick_sync u_sync_1hz (
    .clk   (sclk),
    .rst   (rst),
    .din   (clk_1hz),
    .level (lvl1_unused_s),
    .pulse (tick1_s)
  );

`ifdef STOPWATCH_ADJ_EN
  tick_sync u_sync_2hz (
    .clk   (sclk),
    .rst   (rst),
    .din   (clk_2hz),
    .level (lvl2_s),
    .pulse (tick2_s)
  );
  assign adj_s = adj;
  assign sel_s = sel;
`else
  // Adjust inputs have no effect in this build.
  logic adj_unused_s;
  assign adj_unused_s = ^{adj, sel, clk_2hz};
  assign lvl2_s  = 1'b0;
  assign tick2_s = 1'b0;
  assign adj_s   = 1'b0;
  assign sel_s   = 1'b0;
`endif

  assign sec_at_max_s = (sec_tens_r == SEC_TENS_MAX) && (sec_ones_r == SEC_ONES_MAX);
  assign min_at_max_s = (min_tens_r == MIN_TENS_MAX) && (min_ones_r == MIN_ONES_MAX);
  assign sec_inc_s    = bcd2_inc(sec_tens_r, sec_ones_r, SEC_TENS_MAX, SEC_ONES_MAX);
  assign min_inc_s    = bcd2_inc(min_tens_r, min_ones_r, MIN_TENS_MAX, MIN_ONES_MAX);

  // Next state, field increment enables, wrap and blink requests.
  always_comb begin
    state_next_s     = state_r;
    inc_sec_s        = 1'b0;
    inc_min_s        = 1'b0;
    wrap_next_s      = 1'b0;
    blink_min_next_s = 1'b0;
    blink_sec_next_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        // adj beats a coincident tick1: no increment on entry to ADJUST.
        if (adj_s) begin
          state_next_s = ST_ADJUST;
        end else begin
          if (tick1_s) begin
            inc_sec_s   = 1'b1;
            inc_min_s   = sec_at_max_s;
            wrap_next_s = sec_at_max_s & min_at_max_s;
          end else begin
            inc_sec_s   = 1'b0;
          end
          if (pause_tgl) begin
            state_next_s = ST_PAUSED;
          end else begin
            state_next_s = ST_RUN;
          end
        end
      end
      ST_PAUSED: begin
        if (adj_s) begin
          state_next_s = ST_ADJUST;
        end else if (pause_tgl) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_PAUSED;
        end
      end
`ifdef STOPWATCH_ADJ_EN
      ST_ADJUST: begin
        if (adj_s) begin
          state_next_s = ST_ADJUST;
        end else begin
          state_next_s = ST_PAUSED;
        end
        // Fields adjust independently: no carry and no wrap pulse.
        if (tick2_s) begin
          inc_sec_s = sel_s;
          inc_min_s = ~sel_s;
        end else begin
          inc_sec_s = 1'b0;
        end
        blink_min_next_s = ~sel_s & lvl2_s;
        blink_sec_next_s = sel_s & lvl2_s;
      end
`endif
      default: begin
        state_next_s = ST_RUN;
      end
    endcase
  end

  // State, digit, wrap and blink registers.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state_r     <= ST_RUN;
      min_tens_r  <= 4'd0;
      min_ones_r  <= 4'd0;
      sec_tens_r  <= 4'd0;
      sec_ones_r  <= 4'd0;
      wrap_r      <= 1'b0;
      blink_min_r <= 1'b0;
      blink_sec_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (inc_sec_s) begin
        {sec_tens_r, sec_ones_r} <= sec_inc_s;
      end
      if (inc_min_s) begin
        {min_tens_r, min_ones_r} <= min_inc_s;
      end
      wrap_r      <= wrap_next_s;
      blink_min_r <= blink_min_next_s;
      blink_sec_r <= blink_sec_next_s;
    end
  end

  assign min_tens  = min_tens_r;
  assign min_ones  = min_ones_r;
  assign sec_tens  = sec_tens_r;
  assign sec_ones  = sec_ones_r;
  assign wrap      = wrap_r;
  assign blink_min = blink_min_r;
  assign blink_sec = blink_sec_r;

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

- Timekeeping core of the stopwatch.
- Consumes the 1 Hz and 2 Hz outputs of the clock divider and counts elapsed time as four BCD digits (MM:SS) for the seven-segment display driver.
- All logic runs on the system clock. The divider outputs are sampled as data and turned into single-cycle ticks; they are never used as clocks.
- Supports run/pause, wrap-around and an optional adjust mode.

## Interface

Parameters:
- MAX_MIN, 59, largest minutes value; must be ≤ 99. Seconds maximum is fixed at 59.

Ports:
- sclk  in  1  system clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- clk_1hz  in  1  1 Hz square wave from the divider, sampled as data
- clk_2hz  in  1  2 Hz square wave from the divider, sampled as data
- pause_tgl  in  1  one-cycle pulse, already debounced; toggles RUN/PAUSED
- adj  in  1  level; high selects ADJUST (only when STOPWATCH_ADJ_EN is defined)
- sel  in  1  adjust field: 0 = minutes, 1 = seconds
- min_tens  out  4  BCD minutes tens
- min_ones  out  4  BCD minutes ones
- sec_tens  out  4  BCD seconds tens, range 0–5
- sec_ones  out  4  BCD seconds ones
- wrap  out  1  one-cycle pulse when the count rolls from MAX_MIN:59 to 00:00
- blink_min  out  1  blank minutes digits while high
- blink_sec  out  1  blank seconds digits while high

## Operation

Tick generation:
- clk_1hz and clk_2hz each pass through a two-flop synchronizer and then a rising-edge detector.
- Result: tick1 and tick2, each one sclk cycle wide.

State machine (states RUN, PAUSED, ADJUST):
- Reset: state goes to RUN and all digits go to 0.
- RUN: on tick1, seconds increment. Seconds 59 → 00 carries into minutes. MAX_MIN:59 → 00:00 and wrap pulses.
- RUN → PAUSED on pause_tgl. PAUSED → RUN on pause_tgl.
- PAUSED: digits hold; tick1 is ignored.
- RUN or PAUSED → ADJUST while adj = 1. ADJUST → PAUSED when adj = 0.
- ADJUST:
  - tick1 is ignored; pause_tgl is ignored.
  - On tick2, the selected field increments by 1. Seconds wrap 59 → 00; minutes wrap MAX_MIN → 00.
  - There is no carry between fields, and wrap does not pulse.
- Blink outputs:
  - blink_min = ADJUST & ~sel & synchronized clk_2hz level.
  - blink_sec = ADJUST & sel & synchronized clk_2hz level.
  - Both are 0 outside ADJUST.

Arithmetic:
- Every digit is a separate BCD counter.
- Each digit's carry into the next is computed from the current register values, so there is no ripple across cycles.

Boundary rules:
- rst has priority over every other input.
- Reset mid-operation clears digits, state and synchronizer flops on the same edge.
- If tick1 and pause_tgl coincide in RUN, the increment is applied and the state becomes PAUSED.
- If tick1 and pause_tgl coincide in PAUSED, there is no increment and the state becomes RUN.
- If adj rises in the same cycle as tick1 in RUN, ADJUST wins and there is no increment.
- sel may change at any time and takes effect on the next tick2.

## Timing

- Reset values: all digits 0, wrap = 0, blink_min = 0, blink_sec = 0, state RUN.
- Latency from divider edge to count change:
  - Edge 1 is the first sclk edge that samples clk_1hz high.
  - tick1 is high during the cycle after edge 2.
  - Digits change on edge 3.
  - The same latency applies to clk_2hz → tick2 → adjust increment.
- wrap is registered and high for exactly the one cycle after the digits become 00:00.
- Outputs are registered, with no combinational path from any input to any output.
- pause_tgl takes effect on the edge that samples it.

## Configuration

- Macro: STOPWATCH_ADJ_EN.
- Defined: ADJUST state, tick2 path and blink logic are built as described above.
- Not defined:
  - The ADJUST state and the clk_2hz synchronizer are removed.
  - adj, sel and clk_2hz are ignored.
  - blink_min and blink_sec are tied to 0.
  - RUN/PAUSED behaviour is unchanged.

## Structure

- Package stopwatch_pkg holds:
  - state enum (RUN, PAUSED, ADJUST)
  - BCD digit width constant (4)
  - SEC_MAX = 59
  - default MAX_MIN
- Sub-module tick_sync: two-flop synchronizer plus rising-edge detector with a one-cycle pulse output.
  - Instantiated once for clk_1hz.
  - Instantiated a second time for clk_2hz only under STOPWATCH_ADJ_EN.
  - Also exposes the synchronized level, which the blink logic uses.

## Test plan

- Reset and count:
  - Stimulus: assert rst for 2 cycles, release, then drive 75 clk_1hz rising edges.
  - Response: digits 0,0,0,0 during reset; 01:15 at the end; each increment lands on edge 3 after sampling.
- Wrap:
  - Stimulus: preload to 59:58 through ADJUST, return to RUN, apply 2 ticks.
  - Response: 59:59, then 00:00 with wrap high for exactly 1 cycle.
- Pause:
  - Stimulus: pulse pause_tgl at 00:10, apply 5 ticks, pulse pause_tgl again, apply 3 ticks.
  - Response: holds 00:10, then 00:13.
- Coincidence:
  - Stimulus: pause_tgl in the same cycle as tick1 at 00:20 in RUN.
  - Response: 00:21 and PAUSED; the next tick1 gives no change.
- Adjust (macro on):
  - Stimulus: adj = 1, sel = 1 at 00:58, apply 3 clk_2hz edges; then sel = 0, apply 2 edges.
  - Response:
    - Seconds go 00:59 → 00:00 → 00:01 with minutes unchanged.
    - Then 02:01.
    - blink_sec toggles with clk_2hz while sel = 1; blink_min follows while sel = 0.
- Reset mid-adjust:
  - Stimulus: rst asserted during ADJUST at 12:34.
  - Response: 00:00, state RUN, blink outputs 0 on the next edge.
  - With the macro off, the same adjust stimulus leaves the digits and blink outputs unchanged.
